// File: rtl/neuron_pkg.sv
// Shared types and helpers for the spike interface blocks.
package neuron_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } dec_state_e;

    // Clip a non-negative count to the largest positive value of a signed bits-wide word.
    function automatic int unsigned sat_pos(input int unsigned count, input int unsigned bits);
        int unsigned max_pos;
        max_pos = (32'd1 << (bits - 1)) - 32'd1;
        return (count > max_pos) ? max_pos : count;
    endfunction

endpackage

// File: rtl/spike_window_counter.sv
// Counts sample strobes and spikes over a window; pulses o_window_done on the closing sample.
module spike_window_counter
    import neuron_pkg::*;
#(
    parameter int unsigned WINDOW   = 16,
    parameter int unsigned CNT_BITS = $clog2(WINDOW + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_active,
    input  logic                i_sample,
    input  logic                i_spike,
    output logic [CNT_BITS-1:0] o_count,
    output logic                o_window_done
);

    logic [CNT_BITS-1:0] r_sample_cnt;
    logic [CNT_BITS-1:0] r_spike_cnt;
    logic                w_last;
    logic                w_step;

    assign w_last        = (r_sample_cnt == CNT_BITS'(WINDOW - 1));
    assign w_step        = i_active && i_sample;
    assign o_window_done = w_step && w_last;
    // Includes the current spike so the closing sample is part of the result.
    assign o_count       = r_spike_cnt + CNT_BITS'(i_spike);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample_cnt <= '0;
            r_spike_cnt  <= '0;
        end else if (!i_active || o_window_done) begin
            r_sample_cnt <= '0;
            r_spike_cnt  <= '0;
        end else if (i_sample) begin
            r_sample_cnt <= r_sample_cnt + CNT_BITS'(1);
            r_spike_cnt  <= o_count;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts windowed spike counts into saturated signed data with a one-entry output buffer.
module spike_rate_decoder
    import neuron_pkg::*;
#(
    parameter int unsigned WINDOW    = 16,
    parameter int unsigned data_bits = 4,
    parameter int unsigned CNT_BITS  = $clog2(WINDOW + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sample,
    input  logic                 spike_in,
    output logic [data_bits-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 overrun
);

    dec_state_e          r_state;
    logic [data_bits-1:0] r_data;
    logic                r_valid;
    logic                r_overrun;
    logic                w_active;
    logic                w_done;
    logic                w_free;
    logic [CNT_BITS-1:0] w_count;

    assign w_active = (r_state == ACCUM) && en;
    assign w_free   = !r_valid || data_ready;

    spike_window_counter #(
        .WINDOW   (WINDOW),
        .CNT_BITS (CNT_BITS)
    ) u_counter (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_active      (w_active),
        .i_sample      (sample),
        .i_spike       (spike_in),
        .o_count       (w_count),
        .o_window_done (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= en ? ACCUM : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done && w_free) begin
            r_data  <= data_bits'(sat_pos(32'(w_count), data_bits));
            r_valid <= 1'b1;
        end else if (w_done) begin
            // Buffer still held by an unconsumed result: drop the new one.
            r_overrun <= 1'b1;
        end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder at WINDOW=4, 16 and 1.
module tb_spike_rate_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en4 = 0, smp4 = 0, spk4 = 0, rdy4 = 0;
    logic [3:0] dout4;
    logic       vld4, ovr4;
    logic       en16 = 0, smp16 = 0, spk16 = 0, rdy16 = 0;
    logic [3:0] dout16;
    logic       vld16, ovr16;
    logic       en1 = 0, smp1 = 0, spk1 = 0, rdy1 = 0;
    logic [3:0] dout1;
    logic       vld1, ovr1;

    spike_rate_decoder #(.WINDOW(4), .data_bits(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .sample(smp4), .spike_in(spk4),
        .data_out(dout4), .data_valid(vld4), .data_ready(rdy4), .overrun(ovr4)
    );
    spike_rate_decoder #(.WINDOW(16), .data_bits(4)) u_dut16 (
        .clk(clk), .rst(rst), .en(en16), .sample(smp16), .spike_in(spk16),
        .data_out(dout16), .data_valid(vld16), .data_ready(rdy16), .overrun(ovr16)
    );
    spike_rate_decoder #(.WINDOW(1), .data_bits(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .sample(smp1), .spike_in(spk1),
        .data_out(dout1), .data_valid(vld1), .data_ready(rdy1), .overrun(ovr1)
    );

    typedef struct {
        logic [3:0] spikes;
        logic [3:0] exp_data;
    } vec_t;

    vec_t vecs[5];
    int   n_err = 0;
    int   n_chk = 0;
    int   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake on the WINDOW=4 instance must match the oldest pushed result.
    always @(negedge clk) begin
        if (!rst && vld4 && rdy4) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL d4 unexpected output: got data=%0d, expected no output", dout4);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("d4 scoreboard data", 32'(dout4), e);
            end
        end
    end

    // Called at posedge+1 with the WINDOW=4 instance in ACCUM; returns at posedge+1 after the close.
    task automatic window4(input logic [3:0] spikes, input logic [3:0] rdys);
        for (int i = 0; i < 4; i++) begin
            smp4 = 1'b1;
            spk4 = spikes[i];
            rdy4 = rdys[i];
            @(posedge clk);
            #1;
        end
        smp4 = 1'b0;
        spk4 = 1'b0;
    endtask

    initial begin
        vecs[0] = '{spikes: 4'b1101, exp_data: 4'd3};
        vecs[1] = '{spikes: 4'b0000, exp_data: 4'd0};
        vecs[2] = '{spikes: 4'b1111, exp_data: 4'd4};
        vecs[3] = '{spikes: 4'b0010, exp_data: 4'd1};
        vecs[4] = '{spikes: 4'b0110, exp_data: 4'd2};

        #1 rst = 1'b1;
        en16 = 1'b1;
        en1  = 1'b1;
        #2;
        check("reset data_out", 32'(dout4), 0);
        check("reset data_valid", 32'(vld4), 0);
        check("reset overrun", 32'(ovr4), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        en4 = 1'b1;
        @(posedge clk); #1;

        // Table-driven windows with the consumer always ready.
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(int'(vecs[v].exp_data));
            window4(vecs[v].spikes, 4'b1111);
            @(negedge clk);
            check("t1 valid after close", 32'(vld4), 1);
            check("t1 overrun clear", 32'(ovr4), 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("t1 valid one cycle only", 32'(vld4), 0);
            @(posedge clk); #1;
        end

        // Consumer stalled: second window is dropped and overrun latches.
        window4(4'b0011, 4'b0000);
        @(negedge clk);
        check("t3 window A data", 32'(dout4), 2);
        check("t3 window A valid", 32'(vld4), 1);
        check("t3 overrun before B", 32'(ovr4), 0);
        @(posedge clk); #1;
        window4(4'b0111, 4'b0000);
        @(negedge clk);
        check("t3 data held", 32'(dout4), 2);
        check("t3 valid held", 32'(vld4), 1);
        check("t3 overrun set", 32'(ovr4), 1);
        exp_q.push_back(2);
        @(posedge clk); #1;
        rdy4 = 1'b1;
        @(posedge clk); #1;
        rdy4 = 1'b0;
        @(negedge clk);
        check("t3 valid after consume", 32'(vld4), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3 overrun sticky", 32'(ovr4), 1);

        // Consume coincides with a close: the new result replaces the old without overrun.
        rst = 1'b1;
        #2 rst = 1'b0;
        check("t4 overrun cleared by reset", 32'(ovr4), 0);
        @(posedge clk); #1;
        exp_q.push_back(2);
        window4(4'b0011, 4'b0000);
        exp_q.push_back(1);
        window4(4'b1000, 4'b1000);
        @(negedge clk);
        check("t4 new data", 32'(dout4), 1);
        check("t4 valid kept", 32'(vld4), 1);
        check("t4 no overrun", 32'(ovr4), 0);

        // Partial window discarded by en=0; unsampled spikes ignored.
        @(posedge clk); #1;
        smp4 = 1'b1;
        spk4 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        smp4 = 1'b0;
        en4  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5 no output on abort", 32'(vld4), 0);
        @(posedge clk); #1;
        en4 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            spk4 = ~spk4;
            @(posedge clk); #1;
        end
        spk4 = 1'b0;
        check("t5 unsampled spikes ignored", 32'(vld4), 0);
        exp_q.push_back(1);
        window4(4'b1000, 4'b1111);
        @(negedge clk);
        check("t5 data after discard", 32'(dout4), 1);
        check("t5 valid after discard", 32'(vld4), 1);

        // Asynchronous reset mid-window with a result pending and overrun set.
        @(posedge clk); #1;
        window4(4'b0001, 4'b0000);
        window4(4'b0001, 4'b0000);
        check("t6 overrun before reset", 32'(ovr4), 1);
        check("t6 valid before reset", 32'(vld4), 1);
        smp4 = 1'b1;
        spk4 = 1'b1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("t6 async data_out", 32'(dout4), 0);
        check("t6 async data_valid", 32'(vld4), 0);
        check("t6 async overrun", 32'(ovr4), 0);
        smp4 = 1'b0;
        spk4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(2);
        window4(4'b0101, 4'b1111);
        @(negedge clk);
        check("t6 data after reset", 32'(dout4), 2);
        check("t6 valid after reset", 32'(vld4), 1);
        check("t6 overrun after reset", 32'(ovr4), 0);
        @(posedge clk); #1;

        // WINDOW=16 saturation around the clip point.
        rdy16 = 1'b1;
        for (int v = 0; v < 4; v++) begin
            int n;
            int e;
            case (v)
                0: n = 16;
                1: n = 5;
                2: n = 7;
                default: n = 8;
            endcase
            e = (n > 7) ? 7 : n;
            for (int i = 0; i < 16; i++) begin
                smp16 = 1'b1;
                spk16 = (i < n);
                @(posedge clk); #1;
            end
            smp16 = 1'b0;
            spk16 = 1'b0;
            @(negedge clk);
            check("t2 w16 data", 32'(dout16), e);
            check("t2 w16 valid", 32'(vld16), 1);
            @(posedge clk); #1;
        end

        // WINDOW=1: every sample is its own window.
        rdy1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic b;
            b = (i != 1);
            smp1 = 1'b1;
            spk1 = b;
            @(posedge clk); #1;
            @(negedge clk);
            check("w1 data", 32'(dout1), 32'(b));
            check("w1 valid", 32'(vld1), 1);
        end
        smp1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("w1 valid drops", 32'(vld1), 0);
        check("w1 no overrun", 32'(ovr1), 0);

        check("d4 scoreboard drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receiving end of the neuron spike interface. Samples the 1-bit spike output of a spiking neuron once per neuron evaluation strobe and counts spikes over a fixed window of evaluations. Converts the count back into the signed data_bits-wide potential format that the next neuron layer accepts. Results are delivered through a one-entry output buffer with a valid/ready handshake, and overruns are flagged.

Parameters:
WINDOW, 16, number of sample strobes per window (>=1)
data_bits, 4, width of signed output data, equal to the neuron data_in width
CNT_BITS, $clog2(WINDOW+1), internal spike/sample counter width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  run enable; low forces IDLE and discards the partial window
sample  input  1  strobe, one pulse per neuron evaluation; spike_in valid only when high
spike_in  input  1  spike bit from the upstream neuron data_out
data_out  output  data_bits  signed saturated spike count of the last completed window
data_valid  output  1  data_out holds an unconsumed result
data_ready  input  1  consumer accepts data_out when data_valid&&data_ready
overrun  output  1  sticky: a completed window was dropped because the buffer was full

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, sample_cnt=0, spike_cnt=0, data_out=0, data_valid=0, overrun=0.
- FSM states IDLE and ACCUM.
  - IDLE: counters held at 0; sample is ignored. en=1 moves to ACCUM on the next edge. The first counted sample is in the cycle after the transition.
  - ACCUM, en=0: next state is IDLE, counters cleared, partial window discarded. The output buffer is untouched, so a pending result stays until it is consumed.
  - ACCUM, en=1, sample=1, sample_cnt<WINDOW-1: sample_cnt+=1 and spike_cnt+=spike_in.
  - ACCUM, en=1, sample=1, sample_cnt==WINDOW-1 (window close): result=spike_cnt+spike_in. Counters return to 0 and the state stays ACCUM.
  - ACCUM, sample=0: no change; spike_in is don't-care.
- Saturation: result is clipped to 2**(data_bits-1)-1 (7 for data_bits=4). data_out is never negative. Internal counters are CNT_BITS wide and never wrap inside a window.
- Output buffer:
  - Free when data_valid=0, or when data_valid=1 && data_ready=1 in the same cycle.
  - On window close with the buffer free: data_out<=result and data_valid<=1 on the next edge. Latency is one cycle from the closing sample.
  - On window close with the buffer full (valid=1, ready=0): the result is dropped, data_out is unchanged, and overrun<=1.
  - Consume with no simultaneous close: data_valid<=0, data_out holds its last value.
  - Consume and close in the same cycle: the new result loads, data_valid stays 1, and overrun is not set.
  - data_out is stable while data_valid=1 && data_ready=0.
- overrun is cleared only by rst.
- WINDOW=1: every sample closes a window, and result equals spike_in.

Decomposition:
- Shared package neuron_pkg holds:
  - typedef enum for decoder states {IDLE, ACCUM}
  - a saturating-clip function sat_pos(count, data_bits)
- One sub-module, spike_window_counter, holds the sample and spike counters. It takes en/sample/spike_in and produces count plus a one-cycle window_done pulse. FSM and output buffer stay in the top level.

Test Plan:
1. WINDOW=4, data_bits=4, data_ready=1. en=1, then 4 strobes with spikes 1,0,1,1 → one cycle after the 4th strobe data_out=3 and data_valid=1 for exactly one cycle; overrun=0.
2. WINDOW=16, all 16 strobes with spike=1 → data_out=7 (saturated), data_valid=1.
3. WINDOW=4, data_ready=0. Window A has 2 spikes, then window B has 3 spikes → data_out stays 2, data_valid=1, overrun=1 after B closes. Raise data_ready for one cycle → data_valid=0. overrun stays 1 until rst.
4. WINDOW=4. data_out=2 is pending when data_ready=1 coincides with the close of a window of 1 spike → next cycle data_out=1, data_valid=1, overrun=0.
5. WINDOW=4. Two strobes with spikes 1,1, then en=0 for 2 cycles, then en=1 and 4 strobes with spikes 0,0,0,1 → data_out=1, confirming the partial window was discarded. Toggling spike_in with sample=0 also changes nothing.
6. Assert rst asynchronously mid-window with data_valid=1 → data_out=0, data_valid=0, overrun=0 without waiting for a clock edge. After release, the first full window produces the correct count.
